// File: rtl/ps2_key_tracker_pkg.sv
// Shared PS/2 constants, event layout and rx FSM state type for the key tracker.
package ps2_key_tracker_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_D     = 8'h23;
    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam int         EV_W      = 10;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_key_tracker_rx_frame.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, frame FSM and
// mid-frame timeout. Emits one-cycle byte_valid or frame_err pulses.
module ps2_rx_frame
    import ps2_key_tracker_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps_clk,
    input  logic       ps_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_s;
    logic                   data_s;
    logic                   clk_prev;
    logic                   fall;

    rx_state_t state;
    rx_state_t state_next;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_bit;
    logic [TW-1:0] tcnt;
    logic          timeout;
    logic          good;
    logic          bad;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps_data};
            clk_prev  <= clk_s;
        end
    end

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign fall   = clk_prev & ~clk_s;

    // A fall in the same cycle restarts the count, so it always beats the timeout.
    assign timeout = (state != RX_IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYCLES));

    always_comb begin
        state_next = state;
        good       = 1'b0;
        bad        = 1'b0;
        if (timeout) begin
            state_next = RX_IDLE;
            bad        = 1'b1;
        end else if (fall) begin
            case (state)
                RX_IDLE:   if (!data_s) state_next = RX_DATA;
                RX_DATA:   if (bit_cnt == 3'd7) state_next = RX_PARITY;
                RX_PARITY: state_next = RX_STOP;
                RX_STOP: begin
                    state_next = RX_IDLE;
                    if (odd_parity_ok(shift, par_bit) && data_s) good = 1'b1;
                    else bad = 1'b1;
                end
                default:   state_next = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= RX_IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            tcnt       <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_next;
            byte_valid <= good;
            frame_err  <= bad;
            if (fall && state == RX_IDLE) bit_cnt <= '0;
            if (fall && state == RX_DATA) begin
                shift   <= {data_s, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (fall && state == RX_PARITY) par_bit <= data_s;
            if (fall || state == RX_IDLE) tcnt <= '0;
            else if (!timeout) tcnt <= tcnt + TW'(1);
        end
    end

    assign rx_byte = shift;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end: frame receiver, E0/F0 prefix decoder, per-key held
// bits and a first-word fall-through event FIFO.
module ps2_key_tracker
    import ps2_key_tracker_pkg::*;
#(
    parameter int                    NUM_KEYS       = 2,
    parameter logic [NUM_KEYS*9-1:0] KEY_CODES      = {9'h023, 9'h01C},
    parameter int                    SYNC_STAGES    = 2,
    parameter int                    TIMEOUT_CYCLES = 100000,
    parameter int                    FIFO_DEPTH     = 8
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                ps_clk,
    input  logic                ps_data,
    output logic [NUM_KEYS-1:0] key_held,
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic [7:0]          ev_code,
    output logic                ev_break,
    output logic                ev_ext,
    output logic                frame_err,
    output logic                ev_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0] rx_byte;
    logic       byte_valid;

    ps2_rx_frame #(
        .SYNC_STAGES   (SYNC_STAGES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .resetn    (resetn),
        .ps_clk    (ps_clk),
        .ps_data   (ps_data),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    logic       pend_ext;
    logic       pend_break;
    logic       push;
    ps2_event_t ev_in;

    always_comb begin
        ev_in = {pend_ext, pend_break, rx_byte};
        push  = byte_valid && (rx_byte != PS2_EXT) && (rx_byte != PS2_BRK);
    end

    // A bad frame drops any half-received prefix so it cannot tag the next key.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_ext   <= 1'b0;
            pend_break <= 1'b0;
        end else if (frame_err) begin
            pend_ext   <= 1'b0;
            pend_break <= 1'b0;
        end else if (byte_valid) begin
            if (rx_byte == PS2_EXT) pend_ext <= 1'b1;
            else if (rx_byte == PS2_BRK) pend_break <= 1'b1;
            else begin
                pend_ext   <= 1'b0;
                pend_break <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            key_held <= '0;
        end else if (push) begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                if ({ev_in.ext, ev_in.code} == KEY_CODES[i*9 +: 9]) key_held[i] <= ~ev_in.brk;
            end
        end
    end

    ps2_event_t      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            full;
    logic            pop;
    logic            wr_en;
    ps2_event_t      head;

    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign ev_valid = (count != '0);
    assign pop      = ev_valid && ev_ready;
    assign wr_en    = push && (!full || pop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            ev_overflow <= 1'b0;
        end else begin
            ev_overflow <= push && full && !pop;
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= ev_in;
    end

    assign head     = mem[rd_ptr];
    assign ev_code  = ev_valid ? head.code : '0;
    assign ev_break = ev_valid & head.brk;
    assign ev_ext   = ev_valid & head.ext;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench: drives PS/2 frames on the pins and checks outputs against
// a byte-level model of prefix decoding, held keys and a bounded event queue.
module tb_ps2_key_tracker;

    localparam int HALF  = 20;
    localparam int TO    = 5000;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ps_clk = 1'b1;
    logic       ps_data = 1'b1;
    logic       ev_ready = 1'b0;
    logic [1:0] key_held;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_break;
    logic       ev_ext;
    logic       frame_err;
    logic       ev_overflow;

    always #10 clk = ~clk;

    ps2_key_tracker #(
        .NUM_KEYS      (2),
        .KEY_CODES     ({9'h023, 9'h01C}),
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(TO),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ps_clk     (ps_clk),
        .ps_data    (ps_data),
        .key_held   (key_held),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_code    (ev_code),
        .ev_break   (ev_break),
        .ev_ext     (ev_ext),
        .frame_err  (frame_err),
        .ev_overflow(ev_overflow)
    );

    // Model state
    logic [9:0] exp_q[$];
    logic [8:0] kc[2] = '{9'h01C, 9'h023};
    logic [1:0] m_held = 2'b00;
    bit         m_ext = 1'b0;
    bit         m_brk = 1'b0;
    int         exp_err = 0;
    int         exp_ovf = 0;
    int         seen_err = 0;
    int         seen_ovf = 0;
    int         checks = 0;
    int         passed = 0;
    bit         settled = 1'b0;
    bit         rand_ready = 1'b0;
    logic       ready_fixed = 1'b0;
    logic [9:0] last_pop = '0;
    logic       err_prev = 1'b0;
    logic       ovf_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [9:0] ev;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            ev = {m_ext, m_brk, b};
            if (exp_q.size() >= DEPTH) exp_ovf++;
            else exp_q.push_back(ev);
            for (int i = 0; i < 2; i++)
                if ({m_ext, b} == kc[i]) m_held[i] = ~m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic model_err();
        exp_err++;
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            if (frame_err) begin
                seen_err++;
                check("frame_err_width", {31'd0, err_prev}, 0);
            end
            if (ev_overflow) begin
                seen_ovf++;
                check("ovf_width", {31'd0, ovf_prev}, 0);
            end
            err_prev = frame_err;
            ovf_prev = ev_overflow;
            if (settled) begin
                check("key_held", key_held, m_held);
                check("ev_valid", ev_valid, exp_q.size() != 0);
            end
            if (ev_valid && ev_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL pop_unexpected: got %0h expected no event", {ev_ext, ev_break, ev_code});
                end else begin
                    check("ev_head", {ev_ext, ev_break, ev_code}, exp_q[0]);
                    void'(exp_q.pop_front());
                end
                last_pop = {ev_ext, ev_break, ev_code};
            end
        end else begin
            err_prev = 1'b0;
            ovf_prev = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            ev_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        settled = 1'b0;
        for (int i = 0; i < n; i++) begin
            ps_data = bits[i];
            wait_clk(HALF);
            ps_clk = 1'b0;
            wait_clk(HALF);
            ps_clk = 1'b1;
        end
        ps_data = 1'b1;
        wait_clk(10);
        settled = 1'b1;
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par);
        logic p;
        p = ~(^b) ^ bad_par;
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit bad_par);
        if (bad_par) model_err();
        else model_byte(b);
        send_bits(frame_bits(b, bad_par), 11);
    endtask

    initial begin
        logic [7:0] pool[6];
        logic [7:0] b;
        pool = '{8'hE0, 8'hF0, 8'h1C, 8'h23, 8'h29, 8'h00};

        // Reset state
        wait_clk(5);
        check("reset_outputs", {key_held, ev_valid, ev_code, ev_break, ev_ext, frame_err, ev_overflow}, 0);
        resetn = 1'b1;
        wait_clk(5);
        settled = 1'b1;

        // 1: make of A
        ready_fixed = 1'b1;
        send_byte(8'h1C, 1'b0);
        check("t1_held", key_held, 2'b01);
        check("t1_event", last_pop, 10'h01C);

        // 2: break of A
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        check("t2_held", key_held, 2'b00);
        check("t2_event", last_pop, 10'h11C);

        // 3: extended break of 23
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h23, 1'b0);
        check("t3_held", key_held, 2'b00);
        check("t3_event", last_pop, 10'h323);

        // 4: parity error then good D
        send_byte(8'h23, 1'b1);
        check("t4_err_count", seen_err, 1);
        check("t4_held_bad", key_held, 2'b00);
        send_byte(8'h23, 1'b0);
        check("t4_held_good", key_held, 2'b10);

        // 5: idle fall with data=1, then truncated frame timing out
        send_bits(11'h7FF, 1);
        model_err();
        send_bits(frame_bits(8'h1C, 1'b0), 5);
        wait_clk(TO + 50);
        check("t5_err_count", seen_err, 2);
        send_byte(8'h1C, 1'b0);
        check("t5_held", key_held, 2'b11);
        check("t5_event", last_pop, 10'h01C);

        // 6: overflow with ready held low, then drain
        ready_fixed = 1'b0;
        wait_clk(4);
        for (int i = 0; i < 9; i++) send_byte(8'h29, 1'b0);
        check("t6_ovf_count", seen_ovf, 1);
        check("t6_model_depth", exp_q.size(), DEPTH);
        ready_fixed = 1'b1;
        wait_clk(20);
        check("t6_drained", ev_valid, 0);
        check("t6_last", last_pop, 10'h029);

        // Reset mid-frame with held keys and a queued event
        ready_fixed = 1'b0;
        wait_clk(4);
        send_byte(8'h29, 1'b0);
        settled = 1'b0;
        send_bits(frame_bits(8'h23, 1'b0), 5);
        settled = 1'b0;
        resetn = 1'b0;
        wait_clk(2);
        check("midreset_outputs", {key_held, ev_valid, ev_code, ev_break, ev_ext, frame_err, ev_overflow}, 0);
        exp_q.delete();
        m_held = 2'b00;
        m_ext = 1'b0;
        m_brk = 1'b0;
        ps_clk = 1'b1;
        ps_data = 1'b1;
        wait_clk(3);
        resetn = 1'b1;
        wait_clk(5);
        settled = 1'b1;
        ready_fixed = 1'b1;
        send_byte(8'h23, 1'b0);
        check("post_reset_held", key_held, 2'b10);

        // Random phase
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            b = pool[$urandom_range(0, 5)];
            if (b == 8'h00) b = 8'($urandom_range(1, 255));
            send_byte(b, $urandom_range(0, 7) == 0);
        end
        rand_ready = 1'b0;
        ready_fixed = 1'b1;
        wait_clk(20);
        check("final_err_count", seen_err, exp_err);
        check("final_ovf_count", seen_ovf, exp_ovf);
        check("final_drained", ev_valid, 0);
        check("final_model_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
